// File: rtl/dmem_arbiter.sv
// Shares one block-addressed data memory between the instruction cache and the data cache.
// Build option ROUND_ROBIN_EN: tie-break goes to the port not served last (default: D over I).
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;
  typedef enum logic [1:0] {OwnNone, OwnI, OwnD} owner_e;

  state_e state;
  owner_e owner;
  logic   dir_write;
  logic   i_req;
  logic   d_req;
  logic   grant_d;
  logic   done;

  assign i_req = i_read;
  assign d_req = d_read | d_write;
  assign done  = (state == StDone);

`ifdef ROUND_ROBIN_EN
  logic last_grant_d;

  // On a tie, serve whichever port was not granted last.
  assign grant_d = d_req & (~i_req | ~last_grant_d);

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_d <= 1'b0;
    end else if (state == StIdle && (i_req || d_req)) begin
      last_grant_d <= grant_d;
    end
  end
`else
  assign grant_d = d_req;
`endif

  assign i_busywait = i_req & ~(done & (owner == OwnI));
  assign d_busywait = d_req & ~(done & (owner == OwnD));

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= StIdle;
      owner         <= OwnNone;
      dir_write     <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      i_readdata    <= '0;
      d_readdata    <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (i_req || d_req) begin
            owner       <= grant_d ? OwnD : OwnI;
            mem_address <= grant_d ? d_address : i_address;
            dir_write   <= grant_d & d_write;
            if (grant_d) begin
              mem_writedata <= d_writedata;
            end
            state <= StIssue;
          end
        end
        StIssue: begin
          mem_read  <= ~dir_write;
          mem_write <= dir_write;
          if (mem_busywait) begin
            state <= StWait;
          end
        end
        StWait: begin
          if (!mem_busywait) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (!dir_write) begin
              if (owner == OwnD) begin
                d_readdata <= mem_readdata;
              end else begin
                i_readdata <= mem_readdata;
              end
            end
            state <= StDone;
          end
        end
        StDone: begin
          // Guard cycle: the finishing requester's stale request is not re-granted.
          owner <= OwnNone;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule
